// File: rtl/product_accumulator_pkg.sv
// Shared constants for the product accumulator and the multiplier wrapper.
package product_accumulator_pkg;

    localparam int PROD_W    = 16;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/product_accumulator_adder.sv
// Accumulator plus zero-extended product, with carry out of the top bit.
module acc_adder
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] sum_ext;

    assign sum_ext = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    assign sum_o   = sum_ext[ACC_W-1:0];
    assign carry_o = sum_ext[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator for multiplier products with a valid/ready result port.
//   state | meaning
//   ACCUM | summing beats; in_ready = !clear
//   HOLD  | result presented on out_*; waiting for out_ready
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [0:0] S_ACCUM = ACCUM;
    localparam logic [0:0] S_HOLD  = HOLD;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] sum;
    logic             carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat;

    acc_adder #(.ACC_W(ACC_W)) u_adder (
        .acc_i   (acc_q),
        .prod_i  (in_prod),
        .sum_o   (sum),
        .carry_o (carry)
    );

    // in_ready must not depend on out_ready, so it is derived from state and clear only
    assign in_ready = (state_q == S_ACCUM) && !clear;
    assign beat     = in_valid && in_ready;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            S_ACCUM: begin
                if (clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (beat) begin
                    if (in_last) begin
                        out_acc_d   = sum;
                        out_cnt_d   = cnt_inc;
                        out_ovf_d   = ovf_q | carry;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | carry;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACCUM;
                end
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: three accumulator configurations driven in lockstep from one vector table.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy_a, rdy_b, rdy_c;
    logic        ovld_a, ovld_b, ovld_c;
    logic [23:0] acc_a, acc_c;
    logic [15:0] acc_b;
    logic [7:0]  cnt_a, cnt_b;
    logic [1:0]  cnt_c;
    logic        ovf_a, ovf_b, ovf_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    product_accumulator dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
        .in_prod(in_prod), .in_last(in_last), .out_valid(ovld_a), .out_ready(out_ready),
        .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_a)
    );

    product_accumulator #(.ACC_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
        .in_prod(in_prod), .in_last(in_last), .out_valid(ovld_b), .out_ready(out_ready),
        .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_b)
    );

    product_accumulator #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_c),
        .in_prod(in_prod), .in_last(in_last), .out_valid(ovld_c), .out_ready(out_ready),
        .out_acc(acc_c), .out_count(cnt_c), .out_ovf(ovf_c)
    );

    typedef struct {
        logic        v;
        logic [15:0] prod;
        logic        last;
        logic        clr;
        logic        ordy;
        logic        e_rdy;
        logic        e_ovld;
        logic [23:0] e_acc;
        logic [15:0] e_accb;
        logic [7:0]  e_cnt;
        logic [1:0]  e_cntc;
        logic        e_ovf;
        logic        e_ovfb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [15:0] prod, logic last, logic clr, logic ordy,
                                logic e_rdy, logic e_ovld, logic [23:0] e_acc,
                                logic [15:0] e_accb, logic [7:0] e_cnt, logic [1:0] e_cntc,
                                logic e_ovf, logic e_ovfb);
        vec_t r;
        r.v = v; r.prod = prod; r.last = last; r.clr = clr; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_ovld = e_ovld; r.e_acc = e_acc; r.e_accb = e_accb;
        r.e_cnt = e_cnt; r.e_cntc = e_cntc; r.e_ovf = e_ovf; r.e_ovfb = e_ovfb;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(int idx, logic e_ovld, logic [23:0] e_acc, logic [15:0] e_accb,
                            logic [7:0] e_cnt, logic [1:0] e_cntc, logic e_ovf, logic e_ovfb);
        chk("ovld_a", idx, 32'(ovld_a), 32'(e_ovld));
        chk("ovld_b", idx, 32'(ovld_b), 32'(e_ovld));
        chk("ovld_c", idx, 32'(ovld_c), 32'(e_ovld));
        chk("acc_a",  idx, 32'(acc_a),  32'(e_acc));
        chk("acc_b",  idx, 32'(acc_b),  32'(e_accb));
        chk("acc_c",  idx, 32'(acc_c),  32'(e_acc));
        chk("cnt_a",  idx, 32'(cnt_a),  32'(e_cnt));
        chk("cnt_b",  idx, 32'(cnt_b),  32'(e_cnt));
        chk("cnt_c",  idx, 32'(cnt_c),  32'(e_cntc));
        chk("ovf_a",  idx, 32'(ovf_a),  32'(e_ovf));
        chk("ovf_b",  idx, 32'(ovf_b),  32'(e_ovfb));
        chk("ovf_c",  idx, 32'(ovf_c),  32'(e_ovf));
    endtask

    task automatic drive(logic v, logic [15:0] prod, logic last, logic clr, logic ordy);
        in_valid  = v;
        in_prod   = prod;
        in_last   = last;
        clear     = clr;
        out_ready = ordy;
    endtask

    initial begin
        // basic 3-beat frame; B (16-bit) wraps twice
        vecs.push_back(mk(1, 16'hFE01, 0, 0, 1, 1, 0, 24'h0, 16'h0, 8'd0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 16'hFE01, 0, 0, 1, 1, 0, 24'h0, 16'h0, 8'd0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 16'hFE01, 1, 0, 1, 1, 1, 24'h02FA03, 16'hFA03, 8'd3, 2'd3, 0, 1));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 0, 0, 24'h02FA03, 16'hFA03, 8'd3, 2'd3, 0, 1));
        // two-beat overflow frame, then single-beat frame clears ovf
        vecs.push_back(mk(1, 16'hFE01, 0, 0, 1, 1, 0, 24'h02FA03, 16'hFA03, 8'd3, 2'd3, 0, 1));
        vecs.push_back(mk(1, 16'hFE01, 1, 0, 1, 1, 1, 24'h01FC02, 16'hFC02, 8'd2, 2'd2, 0, 1));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 0, 0, 24'h01FC02, 16'hFC02, 8'd2, 2'd2, 0, 1));
        vecs.push_back(mk(1, 16'h0001, 1, 0, 1, 1, 1, 24'h000001, 16'h0001, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 0, 0, 24'h000001, 16'h0001, 8'd1, 2'd1, 0, 0));
        // backpressure: 5 cycles of out_ready=0 with beats offered
        vecs.push_back(mk(1, 16'h1111, 1, 0, 0, 1, 1, 24'h001111, 16'h1111, 8'd1, 2'd1, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 16'h2222, 0, 0, 0, 0, 1, 24'h001111, 16'h1111, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(1, 16'h2222, 0, 0, 1, 0, 0, 24'h001111, 16'h1111, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 1, 0, 24'h001111, 16'h1111, 8'd1, 2'd1, 0, 0));
        // clear mid-frame drops partial sum and the beat offered with it
        vecs.push_back(mk(1, 16'h0010, 0, 0, 1, 1, 0, 24'h001111, 16'h1111, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(1, 16'h0020, 0, 0, 1, 1, 0, 24'h001111, 16'h1111, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(1, 16'h0100, 0, 1, 1, 0, 0, 24'h001111, 16'h1111, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(1, 16'h0005, 1, 0, 1, 1, 1, 24'h000005, 16'h0005, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 0, 0, 24'h000005, 16'h0005, 8'd1, 2'd1, 0, 0));
        // five beats: C's 2-bit count saturates at 3
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 16'h0001, 0, 0, 1, 1, 0, 24'h000005, 16'h0005, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(1, 16'h0001, 1, 0, 1, 1, 1, 24'h000005, 16'h0005, 8'd5, 2'd3, 0, 0));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 0, 0, 24'h000005, 16'h0005, 8'd5, 2'd3, 0, 0));
        // clear is ignored in HOLD
        vecs.push_back(mk(1, 16'h0007, 1, 0, 0, 1, 1, 24'h000007, 16'h0007, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0, 0, 1, 0, 0, 1, 24'h000007, 16'h0007, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 0, 0, 24'h000007, 16'h0007, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(1, 16'h0003, 1, 0, 1, 1, 1, 24'h000003, 16'h0003, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 0, 0, 24'h000003, 16'h0003, 8'd1, 2'd1, 0, 0));
        // zero-valued beats still count
        vecs.push_back(mk(1, 16'h0000, 0, 0, 1, 1, 0, 24'h000003, 16'h0003, 8'd1, 2'd1, 0, 0));
        vecs.push_back(mk(1, 16'h0000, 1, 0, 1, 1, 1, 24'h000000, 16'h0000, 8'd2, 2'd2, 0, 0));
        vecs.push_back(mk(0, 16'h0, 0, 0, 1, 0, 0, 24'h000000, 16'h0000, 8'd2, 2'd2, 0, 0));

        drive(0, 16'h0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_rdy_a", -1, 32'(rdy_a), 32'd1);
        chk_outs(-1, 0, 24'h0, 16'h0, 8'd0, 2'd0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].prod, vecs[i].last, vecs[i].clr, vecs[i].ordy);
            #1;
            chk("in_ready_a", i, 32'(rdy_a), 32'(vecs[i].e_rdy));
            chk("in_ready_b", i, 32'(rdy_b), 32'(vecs[i].e_rdy));
            @(posedge clk); #1;
            chk_outs(i, vecs[i].e_ovld, vecs[i].e_acc, vecs[i].e_accb, vecs[i].e_cnt,
                     vecs[i].e_cntc, vecs[i].e_ovf, vecs[i].e_ovfb);
        end

        // async reset while in HOLD
        drive(1, 16'h0ABC, 1, 0, 0);
        @(posedge clk); #1;
        chk("hold_pre_rst_ovld", 100, 32'(ovld_a), 32'd1);
        chk("hold_pre_rst_acc", 100, 32'(acc_a), 32'h000ABC);
        drive(0, 16'h0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst_rdy", 101, 32'(rdy_a), 32'd1);
        chk_outs(101, 0, 24'h0, 16'h0, 8'd0, 2'd0, 0, 0);
        #2 rst_n = 1'b1;

        // async reset mid-frame discards the partial sum
        @(posedge clk); #1;
        drive(1, 16'h0100, 0, 0, 1);
        @(posedge clk); #1;
        drive(0, 16'h0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs(102, 0, 24'h0, 16'h0, 8'd0, 2'd0, 0, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 16'h1234, 1, 0, 1);
        @(posedge clk); #1;
        chk_outs(103, 1, 24'h001234, 16'h1234, 8'd1, 2'd1, 0, 0);
        drive(0, 16'h0, 0, 0, 1);
        @(posedge clk); #1;
        chk("post_rst_ovld_drop", 104, 32'(ovld_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
